// File: rtl/uart_tx_serializer.sv
// UART transmit engine: serializes one DATA_BITS word per accepted tx_start as
// start bit, LSB-first data bits and STOP_BITS stop bits on a registered, idle-high line.
//   state   | meaning
//   S_IDLE  | line high, waiting for tx_start
//   S_START | start bit (low) for one bit time
//   S_DATA  | shifting data bits out, LSB first
//   S_STOP  | stop bit(s) high, then pulse tx_done
module uart_tx_serializer #(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(STOP_BITS * CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [IDX_W-1:0]     r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_done;

   logic [1:0]           w_state_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_tx_nxt;
   logic                 w_done_nxt;
   logic                 w_bit_end;

   assign w_bit_end = (r_cnt == BIT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (tx_start) begin
               w_state_nxt = S_START;
               w_shift_nxt = tx_data;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = r_shift >> 1;
               if (r_idx == IDX_LAST) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_STOP;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end
         S_STOP: begin
            // all stop bits are timed as one stretch; the counter is sized for it
            if (r_cnt == STOP_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // line level follows the next state so the start bit appears one cycle after acceptance
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_done  <= w_done_nxt;
      end
   end

   assign tx      = r_tx;
   assign tx_busy = r_busy;
   assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: an 8N1 instance (16 clocks/bit) and a
// 7-data/2-stop instance (4 clocks/bit), with a line decoder feeding a byte scoreboard.
module tb_uart_tx_serializer;

   logic       clk;
   logic       rst;
   logic       start8, start7;
   logic [7:0] data8;
   logic [6:0] data7;
   logic       tx8, busy8, done8;
   logic       tx7, busy7, done7;

   int n_pass  = 0;
   int n_total = 0;
   int n_excl  = 0;

   logic [7:0] sb_q8[$];
   logic [7:0] sb_q7[$];

   typedef struct {
      int         sel;
      logic [7:0] data;
      logic [9:0] pat;
      int         busy_cyc;
      int         pulse_at;
   } vec_t;

   vec_t vecs[7];

   uart_tx_serializer #(
      .CLK_FREQ (16),
      .BAUD     (1),
      .DATA_BITS(8),
      .STOP_BITS(1)
   ) dut8 (
      .clk     (clk),
      .rst     (rst),
      .tx_start(start8),
      .tx_data (data8),
      .tx      (tx8),
      .tx_busy (busy8),
      .tx_done (done8)
   );

   uart_tx_serializer #(
      .CLK_FREQ (4),
      .BAUD     (1),
      .DATA_BITS(7),
      .STOP_BITS(2)
   ) dut7 (
      .clk     (clk),
      .rst     (rst),
      .tx_start(start7),
      .tx_data (data7),
      .tx      (tx7),
      .tx_busy (busy7),
      .tx_done (done7)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   task automatic sample(input int sel, output logic l_tx, output logic l_busy, output logic l_done);
      l_tx   = (sel == 0) ? tx8   : tx7;
      l_busy = (sel == 0) ? busy8 : busy7;
      l_done = (sel == 0) ? done8 : done7;
   endtask

   // Decodes frames off the line by mid-bit sampling and matches them against the scoreboard.
   task automatic mon(input int sel);
      int         cpb;
      int         nd;
      logic       l;
      logic       ab;
      logic [7:0] b;
      logic [7:0] exp;
      cpb = (sel == 0) ? 16 : 4;
      nd  = (sel == 0) ? 8 : 7;
      forever begin
         @(negedge clk);
         l = (sel == 0) ? tx8 : tx7;
         if (!rst && l === 1'b0) begin
            b  = '0;
            ab = 1'b0;
            for (int c = 1; c <= (nd + 1) * cpb + cpb / 2; c++) begin
               @(negedge clk);
               if (rst) begin
                  ab = 1'b1;
                  break;
               end
               l = (sel == 0) ? tx8 : tx7;
               if ((c % cpb) == cpb / 2 && c / cpb >= 1 && c / cpb <= nd) b[c / cpb - 1] = l;
            end
            if (!ab) begin
               check($sformatf("mon%0d_stop", sel), 32'(l), 32'd1);
               if ((sel == 0 && sb_q8.size() == 0) || (sel == 1 && sb_q7.size() == 0)) begin
                  n_total++;
                  $display("FAIL mon%0d_unexpected_frame: got %0h expected no frame", sel, b);
               end else begin
                  exp = (sel == 0) ? sb_q8.pop_front() : sb_q7.pop_front();
                  check($sformatf("mon%0d_byte", sel), 32'(b), 32'(exp));
               end
            end
         end
      end
   endtask

   task automatic excl_watch();
      forever begin
         @(negedge clk);
         if ((busy8 && done8) || (busy7 && done7)) n_excl++;
      end
   endtask

   task automatic run_frame(input int sel, input logic [7:0] data, input logic [9:0] pat,
                            input int busy_cyc, input int pulse_at, input string tag);
      int   cpb;
      int   tx_bad;
      int   busy_bad;
      int   done_bad;
      logic l_tx, l_busy, l_done;
      cpb      = (sel == 0) ? 16 : 4;
      tx_bad   = 0;
      busy_bad = 0;
      done_bad = 0;
      if (sel == 0) begin
         start8 = 1'b1;
         data8  = data;
         sb_q8.push_back(data);
      end else begin
         start7 = 1'b1;
         data7  = data[6:0];
         sb_q7.push_back({1'b0, data[6:0]});
      end
      @(negedge clk);
      start8 = 1'b0;
      start7 = 1'b0;
      for (int c = 0; c < busy_cyc; c++) begin
         sample(sel, l_tx, l_busy, l_done);
         if (l_tx !== pat[c / cpb]) tx_bad++;
         if (l_busy !== 1'b1) busy_bad++;
         if (l_done !== 1'b0) done_bad++;
         if (c == pulse_at) begin
            if (sel == 0) begin start8 = 1'b1; data8 = 8'h3C; end
            else begin start7 = 1'b1; data7 = 7'h3C; end
         end else begin
            start8 = 1'b0;
            start7 = 1'b0;
         end
         @(negedge clk);
      end
      check({tag, "_tx_levels"}, 32'(tx_bad), 32'd0);
      check({tag, "_busy_len"}, 32'(busy_bad), 32'd0);
      check({tag, "_no_early_done"}, 32'(done_bad), 32'd0);
      sample(sel, l_tx, l_busy, l_done);
      check({tag, "_done_pulse"}, {29'd0, l_done, l_busy, l_tx}, 32'b101);
      @(negedge clk);
      sample(sel, l_tx, l_busy, l_done);
      check({tag, "_done_one_cycle"}, {30'd0, l_done, l_busy}, 32'd0);
   endtask

   initial begin
      int bad;
      vecs[0] = '{0, 8'hA5, 10'b1101001010, 160, -1};
      vecs[1] = '{0, 8'h00, 10'b1000000000, 160, -1};
      vecs[2] = '{0, 8'hFF, 10'b1111111110, 160, -1};
      vecs[3] = '{0, 8'h96, 10'b1100101100, 160, 50};
      vecs[4] = '{1, 8'h7F, 10'b1111111110, 40, -1};
      vecs[5] = '{1, 8'h2A, 10'b1101010100, 40, -1};
      vecs[6] = '{0, 8'h3C, 10'b1001111000, 160, -1};

      rst    = 1'b1;
      start8 = 1'b0;
      start7 = 1'b0;
      data8  = '0;
      data7  = '0;
      fork
         mon(0);
         mon(1);
         excl_watch();
      join_none

      repeat (3) @(negedge clk);
      check("rst_outputs8", {29'd0, tx8, busy8, done8}, 32'b100);
      check("rst_outputs7", {29'd0, tx7, busy7, done7}, 32'b100);
      rst = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) bad++;
         if (tx7 !== 1'b1 || busy7 !== 1'b0 || done7 !== 1'b0) bad++;
      end
      check("reset_idle", 32'(bad), 32'd0);

      for (int i = 0; i < 7; i++) begin
         run_frame(vecs[i].sel, vecs[i].data, vecs[i].pat, vecs[i].busy_cyc, vecs[i].pulse_at,
                   $sformatf("v%0d", i));
         bad = 0;
         repeat (200) begin
            @(negedge clk);
            if (busy8 || done8 || busy7 || done7) bad++;
         end
         check($sformatf("v%0d_quiet_after", i), 32'(bad), 32'd0);
      end

      // back-to-back: request held high, data changed mid-frame
      start8 = 1'b1;
      data8  = 8'h00;
      sb_q8.push_back(8'h00);
      @(negedge clk);
      bad = 0;
      for (int c = 0; c < 160; c++) begin
         if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
         if (c == 40) data8 = 8'hFF;
         @(negedge clk);
      end
      check("b2b_busy1", 32'(bad), 32'd0);
      check("b2b_done1", {29'd0, tx8, busy8, done8}, 32'b101);
      sb_q8.push_back(8'hFF);
      @(negedge clk);
      check("b2b_start2", {30'd0, tx8, busy8}, 32'b01);
      start8 = 1'b0;
      bad = 0;
      for (int c = 0; c < 160; c++) begin
         if (busy8 !== 1'b1 || done8 !== 1'b0) bad++;
         @(negedge clk);
      end
      check("b2b_busy2", 32'(bad), 32'd0);
      check("b2b_done2", {29'd0, tx8, busy8, done8}, 32'b101);
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (busy8 || done8) bad++;
      end
      check("b2b_no_third", 32'(bad), 32'd0);

      // reset during data bit 3 of 0x55
      start8 = 1'b1;
      data8  = 8'h55;
      sb_q8.push_back(8'h55);
      @(negedge clk);
      start8 = 1'b0;
      repeat (70) @(negedge clk);
      check("mid_bit3_tx", 32'(tx8), 32'd0);
      #1 rst = 1'b1;
      #1;
      check("rst_async", {29'd0, tx8, busy8, done8}, 32'b100);
      sb_q8.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (busy8 || done8) bad++;
      end
      check("rst_abandoned", 32'(bad), 32'd0);
      run_frame(0, 8'h81, 10'b1100000010, 160, -1, "post_rst");

      repeat (20) @(negedge clk);
      check("sb8_drained", 32'(sb_q8.size()), 32'd0);
      check("sb7_drained", 32'(sb_q7.size()), 32'd0);
      check("busy_done_exclusive", 32'(n_excl), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
